// File: rtl/wnd_spill_ctrl.sv
// Register-window stack controller.
// Tracks the current window pointer (cwp) and the resident window count (occ).
// A call on a full stack spills the oldest window to the memory save area.
// A ret on a single resident window refills the previous window from that area.
// The stall output is held for the whole transfer.
// Optional macro WND_ERR_EN adds the sticky wndErr output.
// wndErr flags a ret with an empty save area, and an overflow whose spill would
// wrap the save pointer. In both cases the strobe has no effect.
module wnd_spill_ctrl #(
  parameter int NWND   = 4,
  parameter int REGS   = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    call,
  input  logic                    ret,
  output logic [$clog2(NWND)-1:0] wnd,
  output logic                    ldWnd,
  output logic                    stall,
  output logic [$clog2(NWND)-1:0] rfWnd,
  output logic [$clog2(REGS)-1:0] rfAddr,
  input  logic [DATA_W-1:0]       rfRdData,
  output logic [DATA_W-1:0]       rfWrData,
  output logic                    rfWrEn,
  output logic [ADDR_W-1:0]       memAddr,
  output logic [DATA_W-1:0]       memWrData,
  output logic                    memWrite,
  output logic                    memRead,
  input  logic [DATA_W-1:0]       memRdData,
  input  logic                    memReady
`ifdef WND_ERR_EN
  ,
  output logic                    wndErr
`endif
);

  localparam int WW = $clog2(NWND);
  localparam int RW = $clog2(REGS);
  localparam int OW = WW + 1;
  localparam logic [OW-1:0]     OCC_FULL = OW'(NWND);
  localparam logic [OW-1:0]     OCC_ONE  = OW'(1);
  localparam logic [RW-1:0]     IDX_LAST = RW'(REGS - 1);
  localparam logic [ADDR_W-1:0] REGS_A   = ADDR_W'(REGS);

  typedef enum logic [1:0] {IDLE, SPILL, FILL, DONE} stateE;

  stateE             state, stateN;
  logic [WW-1:0]     cwp, cwpN;
  logic [OW-1:0]     occ, occN;
  logic [ADDR_W-1:0] sp, spN;
  logic [RW-1:0]     idx, idxN;
  logic              fromFill, fromFillN;

`ifdef WND_ERR_EN
  logic              errN;
  logic [ADDR_W:0]   spSum;
  assign spSum = {1'b0, sp} + {1'b0, REGS_A};
`endif

  assign wnd = cwp;

  // State register; reset aborts any transfer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cwp      <= '0;
      occ      <= OCC_ONE;
      sp       <= '0;
      idx      <= '0;
      fromFill <= 1'b0;
`ifdef WND_ERR_EN
      wndErr   <= 1'b0;
`endif
    end else begin
      state    <= stateN;
      cwp      <= cwpN;
      occ      <= occN;
      sp       <= spN;
      idx      <= idxN;
      fromFill <= fromFillN;
`ifdef WND_ERR_EN
      wndErr   <= errN;
`endif
    end
  end

  // Next-state and output decode.
  // The decode is gated by rst, so outputs drop to zero as soon as reset rises.
  always_comb begin
    stateN    = state;
    cwpN      = cwp;
    occN      = occ;
    spN       = sp;
    idxN      = idx;
    fromFillN = fromFill;
`ifdef WND_ERR_EN
    errN      = wndErr;
`endif
    ldWnd     = 1'b0;
    stall     = 1'b0;
    rfWnd     = '0;
    rfAddr    = '0;
    rfWrData  = '0;
    rfWrEn    = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (call) begin
            if (occ != OCC_FULL) begin
              cwpN  = cwp + 1'b1;
              occN  = occ + 1'b1;
              ldWnd = 1'b1;
            end
`ifdef WND_ERR_EN
            else if (spSum[ADDR_W]) begin
              errN = 1'b1;
            end
`endif
            else begin
              stall     = 1'b1;
              stateN    = SPILL;
              idxN      = '0;
              fromFillN = 1'b0;
            end
          end else if (ret) begin
            if (occ > OCC_ONE) begin
              cwpN  = cwp - 1'b1;
              occN  = occ - 1'b1;
              ldWnd = 1'b1;
            end else if (sp != '0) begin
              stall     = 1'b1;
              stateN    = FILL;
              idxN      = '0;
              fromFillN = 1'b1;
            end else begin
`ifdef WND_ERR_EN
              errN = 1'b1;
`endif
            end
          end
        end
        SPILL: begin
          stall     = 1'b1;
          rfWnd     = cwp + 1'b1;
          rfAddr    = idx;
          memAddr   = sp + ADDR_W'(idx);
          memWrData = rfRdData;
          memWrite  = 1'b1;
          if (memReady) begin
            if (idx == IDX_LAST) begin
              idxN   = '0;
              spN    = sp + REGS_A;
              stateN = DONE;
            end else begin
              idxN = idx + 1'b1;
            end
          end
        end
        FILL: begin
          stall   = 1'b1;
          rfWnd   = cwp - 1'b1;
          rfAddr  = idx;
          memAddr = sp - REGS_A + ADDR_W'(idx);
          memRead = 1'b1;
          if (memReady) begin
            rfWrEn   = 1'b1;
            rfWrData = memRdData;
            if (idx == IDX_LAST) begin
              idxN   = '0;
              spN    = sp - REGS_A;
              stateN = DONE;
            end else begin
              idxN = idx + 1'b1;
            end
          end
        end
        DONE: begin
          stall  = 1'b1;
          ldWnd  = 1'b1;
          cwpN   = fromFill ? cwp - 1'b1 : cwp + 1'b1;
          stateN = IDLE;
        end
        default: stateN = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wnd_spill_ctrl.sv
// Testbench for wnd_spill_ctrl.
// The bench models the register file and the memory.
// A window-stack reference model predicts every strobe's effect.
module tb_wnd_spill_ctrl;
  localparam int NWND = 4, REGS = 8, DATA_W = 8, ADDR_W = 8;

  logic clk = 1'b0;
  logic rst, call, ret;
  logic [1:0] wnd, rfWnd;
  logic [2:0] rfAddr;
  logic ldWnd, stall, rfWrEn, memWrite, memRead, memReady;
  logic [7:0] rfRdData, rfWrData, memAddr, memWrData, memRdData;
`ifdef WND_ERR_EN
  logic wndErr;
  bit   mErr;
`endif

  logic [7:0] rf     [NWND][REGS];
  logic [7:0] expRf  [NWND][REGS];
  logic [7:0] mem    [256];
  logic [7:0] expMem [256];
  int mCwp, mOcc, mSp;
  int compared, mismatched;

  wnd_spill_ctrl #(.NWND(NWND), .REGS(REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .call(call), .ret(ret), .wnd(wnd), .ldWnd(ldWnd),
    .stall(stall), .rfWnd(rfWnd), .rfAddr(rfAddr), .rfRdData(rfRdData),
    .rfWrData(rfWrData), .rfWrEn(rfWrEn), .memAddr(memAddr),
    .memWrData(memWrData), .memWrite(memWrite), .memRead(memRead),
    .memRdData(memRdData), .memReady(memReady)
`ifdef WND_ERR_EN
    , .wndErr(wndErr)
`endif
  );

  assign rfRdData  = rf[rfWnd][rfAddr];
  assign memRdData = mem[memAddr];

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Apply the DUT's RF/memory writes for this cycle, then advance past the edge.
  task automatic tick();
    if (memWrite && memReady) mem[memAddr] = memWrData;
    if (rfWrEn) rf[rfWnd][rfAddr] = rfWrData;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    call = 1'b0; ret = 1'b0; memReady = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    mCwp = 0; mOcc = 1; mSp = 0;
`ifdef WND_ERR_EN
    mErr = 1'b0;
`endif
  endtask

  // Emulate the core writing fresh values into the current window.
  task automatic scribble();
    logic [7:0] v;
    for (int r = 0; r < REGS; r++) begin
      v = 8'($urandom);
      rf[mCwp][r] = v;
      expRf[mCwp][r] = v;
    end
  endtask

  // Issue one call/ret strobe, follow it to completion, and check the result.
  task automatic doStrobe(input bit isCall, input int waitWord, input int waitLen,
                          input bit randReady, input string tag);
    int kind, wnd2, base, word, waits, stallCnt, wcnt;
    bit done, ok;
    logic [7:0] eAddr;
    if (isCall) kind = (mOcc < NWND) ? 0 : 1;
    else if (mOcc > 1) kind = 0;
    else if (mSp != 0) kind = 2;
    else kind = 3;
`ifdef WND_ERR_EN
    if (kind == 1 && mSp + REGS >= 256) kind = 3;
    if (kind == 3) mErr = 1'b1;
`endif
    wnd2 = isCall ? (mCwp + 1) % NWND : (mCwp + NWND - 1) % NWND;
    base = (kind == 2) ? (mSp - REGS + 256) % 256 : mSp;
    call = isCall;
    ret = isCall ? 1'($urandom % 2) : 1'b1;
    memReady = 1'b1;
    #1;
    compared++;
    if (ldWnd !== 1'(kind == 0) || stall !== 1'(kind == 1 || kind == 2) ||
        memWrite !== 1'b0 || memRead !== 1'b0) begin
      mismatched++;
      $display("FAIL %s strobe: ldWnd=%b stall=%b memWrite=%b memRead=%b, kind %0d expected",
               tag, ldWnd, stall, memWrite, memRead, kind);
    end
    tick();
    if (kind == 0 || kind == 3) begin
      call = 1'b0; ret = 1'b0;
      if (kind == 0) begin
        mCwp = wnd2;
        mOcc = isCall ? mOcc + 1 : mOcc - 1;
      end
      #1;
      compared++;
      if (wnd !== 2'(mCwp) || stall !== 1'b0 || ldWnd !== 1'b0) begin
        mismatched++;
        $display("FAIL %s after: wnd=%0d stall=%b ldWnd=%b, expected wnd=%0d", tag, wnd, stall, ldWnd, mCwp);
      end
`ifdef WND_ERR_EN
      compared++;
      if (wndErr !== mErr) begin
        mismatched++;
        $display("FAIL %s wndErr: got %b expected %b", tag, wndErr, mErr);
      end
`endif
      return;
    end
    word = 0; waits = 0; stallCnt = 0; wcnt = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (randReady) memReady = ($urandom % 3 != 0);
      else if (word == waitWord && wcnt < waitLen) begin memReady = 1'b0; wcnt++; end
      else memReady = 1'b1;
      #1;
      if (stall) stallCnt++;
      if (word < REGS) begin
        eAddr = 8'(base + word);
        compared++;
        if (kind == 1)
          ok = memWrite === 1'b1 && memRead === 1'b0 && memAddr === eAddr && rfWnd === 2'(wnd2) &&
               rfAddr === 3'(word) && memWrData === expRf[wnd2][word] && stall === 1'b1;
        else
          ok = memRead === 1'b1 && memWrite === 1'b0 && memAddr === eAddr && rfWnd === 2'(wnd2) &&
               rfAddr === 3'(word) && rfWrEn === memReady && stall === 1'b1 &&
               (!memReady || rfWrData === expMem[eAddr]);
        if (!ok) begin
          mismatched++;
          $display("FAIL %s word %0d: addr=%0d wr=%b rd=%b rfWnd=%0d rfAddr=%0d, expected addr=%0d wnd=%0d",
                   tag, word, memAddr, memWrite, memRead, rfWnd, rfAddr, eAddr, wnd2);
        end
        if (!memReady) waits++; else word++;
      end else begin
        compared++;
        if (ldWnd !== 1'b1 || stall !== 1'b1 || memWrite !== 1'b0 || memRead !== 1'b0) begin
          mismatched++;
          $display("FAIL %s done cycle: ldWnd=%b stall=%b, expected 1 1", tag, ldWnd, stall);
        end
        done = 1'b1;
      end
      tick();
    end
    call = 1'b0; ret = 1'b0;
    if (!done) begin
      compared++; mismatched++;
      $display("FAIL %s timeout: transfer did not finish, word=%0d", tag, word);
    end
    if (kind == 1) begin
      for (int i = 0; i < REGS; i++) expMem[(mSp + i) % 256] = expRf[wnd2][i];
      mSp = (mSp + REGS) % 256;
    end else begin
      for (int i = 0; i < REGS; i++) expRf[wnd2][i] = expMem[(base + i) % 256];
      mSp = base;
    end
    mCwp = wnd2;
    #1;
    compared++;
    if (stallCnt !== REGS + 1 + waits) begin
      mismatched++;
      $display("FAIL %s stall length: got %0d expected %0d", tag, stallCnt, REGS + 1 + waits);
    end
    compared++;
    if (wnd !== 2'(mCwp) || stall !== 1'b0) begin
      mismatched++;
      $display("FAIL %s end: wnd=%0d stall=%b, expected wnd=%0d stall=0", tag, wnd, stall, mCwp);
    end
    ok = 1'b1;
    for (int i = 0; i < REGS; i++)
      if (kind == 1 ? mem[(base + i) % 256] !== expMem[(base + i) % 256]
                    : rf[wnd2][i] !== expRf[wnd2][i]) ok = 1'b0;
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s data: transferred words differ from reference (kind %0d, base %0d)", tag, kind, base);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; call = 1'b0; ret = 1'b0; memReady = 1'b0;
    #2;
    compared++;
    if ({wnd, ldWnd, stall, rfWnd, rfAddr, rfWrData, rfWrEn, memAddr, memWrData, memWrite, memRead} !== '0) begin
      mismatched++;
      $display("FAIL reset outputs: wnd=%0d ldWnd=%b stall=%b memWrite=%b memRead=%b addr=%0d, expected all 0",
               wnd, ldWnd, stall, memWrite, memRead, memAddr);
    end
`ifdef WND_ERR_EN
    compared++;
    if (wndErr !== 1'b0) begin mismatched++; $display("FAIL reset wndErr: got %b expected 0", wndErr); end
`endif
    doReset();
  endtask

  task automatic preloadWnd0();
    logic [7:0] v;
    for (int i = 0; i < REGS; i++) begin
      v = 8'(8'h10 + i);
      rf[0][i] = v;
      expRf[0][i] = v;
    end
  endtask

  task automatic test_calls();
    doReset();
    for (int i = 0; i < 3; i++) doStrobe(1'b1, -1, 0, 1'b0, "call");
    compared++;
    if (wnd !== 2'd3) begin mismatched++; $display("FAIL calls wnd: got %0d expected 3", wnd); end
  endtask

  task automatic test_spill();
    bit ok;
    doReset();
    preloadWnd0();
    for (int i = 0; i < 3; i++) doStrobe(1'b1, -1, 0, 1'b0, "spill_pre");
    doStrobe(1'b1, -1, 0, 1'b0, "spill");
    ok = 1'b1;
    for (int i = 0; i < REGS; i++) if (mem[i] !== 8'(8'h10 + i)) ok = 1'b0;
    compared++;
    if (!ok || wnd !== 2'd0 || mSp != 8) begin
      mismatched++;
      $display("FAIL spill result: wnd=%0d ok=%b, expected wnd=0 mem[0..7]=10..17", wnd, ok);
    end
  endtask

  task automatic test_spill_wait();
    doReset();
    preloadWnd0();
    for (int i = 0; i < REGS; i++) mem[i] = 8'hee;
    for (int i = 0; i < 3; i++) doStrobe(1'b1, -1, 0, 1'b0, "wait_pre");
    doStrobe(1'b1, 3, 2, 1'b0, "spill_wait");
  endtask

  task automatic test_fill();
    bit ok;
    for (int i = 0; i < 3; i++) doStrobe(1'b0, -1, 0, 1'b0, "ret");
    for (int i = 0; i < REGS; i++) rf[0][i] = 8'($urandom);
    doStrobe(1'b0, -1, 0, 1'b0, "fill");
    ok = 1'b1;
    for (int i = 0; i < REGS; i++) if (rf[0][i] !== 8'(8'h10 + i)) ok = 1'b0;
    compared++;
    if (!ok || wnd !== 2'd0 || mSp != 0) begin
      mismatched++;
      $display("FAIL fill result: wnd=%0d ok=%b, expected wnd=0 rf[0]=10..17", wnd, ok);
    end
  endtask

  task automatic test_reset_mid_spill();
    doReset();
    for (int i = 0; i < 3; i++) doStrobe(1'b1, -1, 0, 1'b0, "rst_pre");
    call = 1'b1; memReady = 1'b1;
    #1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    compared++;
    if (memWrite !== 1'b1 || memAddr !== 8'd4) begin
      mismatched++;
      $display("FAIL mid-spill position: memWrite=%b addr=%0d, expected 1 4", memWrite, memAddr);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (memWrite !== 1'b0 || stall !== 1'b0 || ldWnd !== 1'b0 || wnd !== 2'd0) begin
      mismatched++;
      $display("FAIL async abort: memWrite=%b stall=%b ldWnd=%b wnd=%0d, expected all 0", memWrite, stall, ldWnd, wnd);
    end
    call = 1'b0;
    doReset();
    doStrobe(1'b0, -1, 0, 1'b0, "ret_empty");
  endtask

`ifdef WND_ERR_EN
  task automatic test_wnd_err();
    doReset();
    doStrobe(1'b0, -1, 0, 1'b0, "err_ret");
    compared++;
    if (wndErr !== 1'b1 || wnd !== 2'd0) begin
      mismatched++;
      $display("FAIL wndErr set: wndErr=%b wnd=%0d, expected 1 0", wndErr, wnd);
    end
    doReset();
  endtask
`endif

  task automatic test_random();
    int r;
    doReset();
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom % 8);
      if ($urandom % 3 == 0) scribble();
      if (r < 4) doStrobe(1'b1, -1, 0, 1'b1, "rand_call");
      else if (r < 7) doStrobe(1'b0, -1, 0, 1'b1, "rand_ret");
      else begin
        call = 1'b0; ret = 1'b0; memReady = 1'(($urandom % 2));
        #1;
        compared++;
        if (ldWnd !== 1'b0 || stall !== 1'b0 || wnd !== 2'(mCwp)) begin
          mismatched++;
          $display("FAIL idle: ldWnd=%b stall=%b wnd=%0d, expected 0 0 %0d", ldWnd, stall, wnd, mCwp);
        end
        tick();
      end
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; call = 1'b0; ret = 1'b0; memReady = 1'b0;
    for (int w = 0; w < NWND; w++)
      for (int i = 0; i < REGS; i++) begin
        rf[w][i] = 8'($urandom);
        expRf[w][i] = rf[w][i];
      end
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'($urandom);
      expMem[a] = mem[a];
    end
    test_reset();
    test_calls();
    test_spill();
    test_spill_wait();
    test_fill();
    test_reset_mid_spill();
`ifdef WND_ERR_EN
    test_wnd_err();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wnd_spill_ctrl.md
# wnd_spill_ctrl

Register-window stack controller for the single-cycle core. It sits between the control unit's call/return strobes and the windowed register file plus data memory. It tracks the current window pointer and the number of resident windows. On window overflow it stalls the PC and spills the oldest window to a memory save area; on underflow it refills the previous window from memory before releasing the stall.

## Interface
Parameters:
- NWND, 4: physical windows (power of 2, ≥2).
- REGS, 8: registers per window (power of 2).
- DATA_W, 8: register/memory word width.
- ADDR_W, 8: save-area address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- call  in  1  CU strobe: open new window.
- ret  in  1  CU strobe: close current window.
- wnd  out  log2(NWND)  current window pointer (to aluCU/RF window select).
- ldWnd  out  1  one-cycle pulse: window pointer changed this edge.
- stall  out  1  hold PC and suppress regWrite/memWrite from CU.
- rfWnd  out  log2(NWND)  window addressed by spill/fill port.
- rfAddr  out  log2(REGS)  register index for spill/fill port.
- rfRdData  in  DATA_W  combinational RF read of (rfWnd, rfAddr).
- rfWrData  out  DATA_W  fill write data.
- rfWrEn  out  1  fill write enable.
- memAddr  out  ADDR_W  save-area address.
- memWrData  out  DATA_W  spill data.
- memWrite  out  1  spill write request, held until memReady.
- memRead  out  1  fill read request, held until memReady.
- memRdData  in  DATA_W  fill data, valid when memReady=1.
- memReady  in  1  memory accepts/returns one word this cycle.

## Operation
- State: cwp (log2 NWND), occ (1..NWND resident windows), sp (ADDR_W save pointer), idx (log2 REGS), FSM {IDLE, SPILL, FILL, DONE}.
- call and ret both high: call wins and ret is ignored.
- IDLE, call, occ<NWND: cwp←cwp+1 (mod NWND), occ←occ+1, ldWnd=1. No stall.
- IDLE, call, occ==NWND: overflow. stall=1 combinationally in the same cycle. victim=cwp+1 (mod NWND). Go to SPILL with idx=0.
- SPILL: rfWnd=victim, rfAddr=idx, memAddr=sp+idx, memWrData=rfRdData, memWrite=1. On memReady, idx increments. On memReady with idx==REGS-1: sp←sp+REGS, go to DONE.
- IDLE, ret, occ>1: cwp←cwp-1, occ←occ-1, ldWnd=1.
- IDLE, ret, occ==1, sp≠0: underflow. stall=1. target=cwp-1. Go to FILL with idx=0.
- FILL: rfWnd=target, rfAddr=idx, memAddr=sp-REGS+idx, memRead=1. When memReady: rfWrEn=1, rfWrData=memRdData, idx increments. On the last word: sp←sp-REGS, go to DONE.
- IDLE, ret, occ==1, sp==0: no-op. See Configuration.
- DONE: stall=1 and ldWnd=1; return to IDLE.
  - After a spill: cwp←cwp+1 and occ unchanged.
  - After a fill: cwp←cwp-1 and occ unchanged (stays 1).
- call and ret are ignored outside IDLE. The CU holds them under stall, and they are re-sampled in IDLE only as new strobes after DONE; the CU must not reissue them.
- sp arithmetic wraps mod 2^ADDR_W.

## Timing
- Reset values:
  - cwp=0, occ=1, sp=0, idx=0, state=IDLE.
  - All outputs 0: wnd, ldWnd, stall, rfWrEn, memWrite, memRead, addresses, data.
- Asserting rst mid-spill or mid-fill aborts at once. memWrite/memRead drop asynchronously and no partial pointer update survives.
- Non-trapping call/ret: ldWnd pulses in the strobe cycle and wnd updates at that edge. Zero stall cycles.
- Spill/fill cost with memReady tied high: REGS transfer cycles plus 1 DONE cycle, so stall is high for REGS+1 cycles after the strobe cycle.
- Each memReady=0 cycle extends the transfer by one cycle. memAddr, data and the request are held stable while waiting.

## Configuration
- Macro WND_ERR_EN.
- Defined: adds output wndErr (1 bit, reset 0, sticky until rst). It is set on either of:
  - ret with occ==1 and sp==0;
  - a call overflow when sp+REGS would wrap past 2^ADDR_W.
  The offending strobe is then a no-op: no spill and no pointer change.
- Undefined: wndErr port is absent. Underflow with empty save area is a silent no-op, and the save area wraps.

## Test plan
- Reset, then 3 calls (NWND=4), no stall → wnd=3, occ=4, three ldWnd pulses, stall never high.
- 4th call with memReady=1, RF window 0 holding 0x10..0x17 → memWrite at addresses 0..7 with data 0x10..0x17. Stall is high for 9 cycles, then wnd=0 and sp=8.
- Same spill with memReady low for 2 cycles on word 3 → addr 3 and its data held 2 extra cycles; stall is high for 11 cycles.
- From occ=1, sp=8, issue ret → memRead at addresses 0..7, rfWrEn writes into window cwp-1, then sp=0 and wnd decrements.
- Assert rst during SPILL at idx=4 → memWrite and stall low immediately; after release wnd=0, sp=0.
- WND_ERR_EN: ret at reset state → wndErr=1, wnd stays 0, no memRead.
